iic_gyro_seq: RTL and testbench
===============================

IIC_GYRO_SEQ -- requirements
Module: iic_gyro_seq

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 8'hD0: 8-bit write slave address driven on Addr.
REQ-002 The block SHALL have parameter BOOT_CYC, default 2000000: number of clk cycles to wait after reset before the first transaction.
REQ-003 The block SHALL have parameter SAMPLE_DIV, default 100000: number of clk cycles between read-burst starts.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 200000: maximum number of clk cycles from request to completion.
REQ-005 The block SHALL have parameter RD_BASE, default 8'h43: first register address of the 6-byte read burst.
REQ-006 The block SHALL have port clk, input, 1 bit: system clock, 100 MHz.
REQ-007 The block SHALL have port Rst, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port en, input, 1 bit: enables periodic sampling.
REQ-009 The block SHALL have ports Addr (output, 8 bits), Reg_Addr (output, 16 bits), Data (output, 8 bits) and Reg_2Addr (output, 1 bit), which drive the IIC driver's request fields.
REQ-010 The block SHALL have ports IIC_Write and IIC_Read, output, 1 bit each: level request strobes to the driver.
REQ-011 The block SHALL have port IIC_Busy, input, 1 bit: driver busy flag, high only during the driver's STOP phase.
REQ-012 The block SHALL have port IIC_Read_Data, input, 8 bits: byte returned by the driver.
REQ-013 The block SHALL have ports gyro_x, gyro_y and gyro_z, output, 16 bits each: last complete sample.
REQ-014 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse when a new sample is published.
REQ-015 The block SHALL have port init_done, output, 1 bit: high once the init table has been written.
REQ-016 The block SHALL have port err, output, 1 bit: sticky flag; set on timeout, cleared on the next successful publish.
REQ-017 The block SHALL have port err_cnt, output, 8 bits: timeout count, saturating at 255.

Function
REQ-018 Addr SHALL be held at DEV_ADDR, and Reg_Addr[15:8] and Reg_2Addr SHALL be held at 0.
REQ-019 The FSM SHALL have the states BOOT, INIT_REQ, INIT_WAIT, IDLE, RD_REQ, RD_WAIT, PUBLISH and ERR.
REQ-020 BOOT SHALL count BOOT_CYC cycles and then go to INIT_REQ with init index 0.
REQ-021 The init table SHALL be the fixed (reg, data) pairs: (0x6B,0x00), (0x19,0x07), (0x1A,0x06), (0x1B,0x18).
REQ-022 In INIT_REQ the block SHALL drive Reg_Addr[7:0] and Data from the table, assert IIC_Write, and hold it until IIC_Busy is sampled high, then deassert it and enter INIT_WAIT.
REQ-023 Transaction completion SHALL be defined as IIC_Busy high on the previous cycle and low on the current cycle (falling edge).
REQ-024 On completion in INIT_WAIT the block SHALL increment the index; after index 3 completes it SHALL set init_done and go to IDLE, otherwise it SHALL return to INIT_REQ.
REQ-025 A free-running sample timer SHALL count 0..SAMPLE_DIV-1 once init_done is high, and SHALL wrap to 0.
REQ-026 IDLE SHALL go to RD_REQ, with byte index 0, at timer==0 only when en is high; a tick that arrives while a burst is in progress SHALL be dropped, not queued.
REQ-027 In RD_REQ the block SHALL drive Reg_Addr[7:0]=RD_BASE+index and assert IIC_Read using the same hold-until-busy rule as REQ-022.
REQ-028 On completion in RD_WAIT the block SHALL store IIC_Read_Data in byte buffer[index]; after index 5 it SHALL go to PUBLISH, otherwise it SHALL increment the index and return to RD_REQ.
REQ-029 PUBLISH SHALL last one cycle: gyro_x={b0,b1}, gyro_y={b2,b3}, gyro_z={b4,b5}, data_valid=1 and err cleared, then go to IDLE.
REQ-030 Outputs SHALL update only in PUBLISH; a partial burst SHALL never be visible on the outputs.
REQ-031 A timeout counter SHALL clear on entry to any *_REQ state and count through *_REQ and *_WAIT.
REQ-032 When the timeout counter reaches TIMEOUT_CYC, the block SHALL enter ERR, drop the strobes, set err and increment err_cnt.
REQ-033 ERR SHALL wait SAMPLE_DIV cycles and then retry: it SHALL go to INIT_REQ with index 0 if init_done is 0, otherwise to IDLE.
REQ-034 IIC_Write and IIC_Read SHALL never be high in the same cycle.
REQ-035 Each strobe SHALL be low for at least 2 cycles between requests, so the driver's rising-edge detector sees each request.
REQ-036 When en is deasserted mid-burst, the current burst SHALL complete and publish, and no new burst SHALL start.

Reset
REQ-037 While Rst is low, the block SHALL force state BOOT with all counters and indices at 0.
REQ-038 While Rst is low, the block SHALL force IIC_Write=0, IIC_Read=0, Reg_Addr=0, Data=0, gyro_*=0, data_valid=0, init_done=0, err=0 and err_cnt=0.
REQ-039 Assertion of Rst mid-transaction SHALL abort immediately, and after release the full boot and init sequence SHALL rerun.

Verification
(Bench parameters: BOOT_CYC=10, SAMPLE_DIV=5000, TIMEOUT_CYC=3000, with a behavioural driver model.)
REQ-040 Init: release reset -> exactly 4 writes are issued, in order (6B,00), (19,07), (1A,06), (1B,18); init_done rises after the 4th busy falling edge.
REQ-041 Burst: model returns 0x12,0x34,0x56,0x78,0x9A,0xBC -> reads of regs 0x43..0x48; one data_valid pulse with gyro_x=0x1234, gyro_y=0x5678, gyro_z=0x9ABC.
REQ-042 Timeout: model never asserts busy on the 3rd read -> err=1 and err_cnt=1 after 3000 cycles; the next good burst publishes and clears err with err_cnt still 1.
REQ-043 en low: deassert en during byte 2 -> that burst publishes, then no further IIC_Read for 3 sample periods; reassert en -> a burst starts at the next timer==0.
REQ-044 Reset mid-read: pull Rst low during RD_WAIT -> all outputs return to 0 within the reset; after release the init sequence is reissued.
REQ-045 Protocol check: across all tests IIC_Write and IIC_Read are never high together, and each strobe has a low gap of at least 2 cycles.

Source files
------------

// File: rtl/iic_gyro_seq_if.sv
// -----------------------------------------------------------------------------
// iic_gyro_seq_if
// Request/response bundle between the gyro sequencer and the IIC byte driver.
//   Addr          : 8-bit device (write) address
//   Reg_Addr      : 16-bit register address (upper byte unused, held at 0)
//   Data          : byte to write
//   Reg_2Addr     : two-byte register address select (held at 0)
//   IIC_Write     : level write request strobe
//   IIC_Read      : level read request strobe
//   IIC_Busy      : driver busy flag, high only during the driver's STOP phase
//   IIC_Read_Data : byte returned by the driver on a read
// master = sequencer side, slave = driver side.
// -----------------------------------------------------------------------------
interface iic_gyro_seq_if;
    logic [7:0]  Addr;
    logic [15:0] Reg_Addr;
    logic [7:0]  Data;
    logic        Reg_2Addr;
    logic        IIC_Write;
    logic        IIC_Read;
    logic        IIC_Busy;
    logic [7:0]  IIC_Read_Data;

    modport master (
        output Addr, Reg_Addr, Data, Reg_2Addr, IIC_Write, IIC_Read,
        input  IIC_Busy, IIC_Read_Data
    );

    modport slave (
        input  Addr, Reg_Addr, Data, Reg_2Addr, IIC_Write, IIC_Read,
        output IIC_Busy, IIC_Read_Data
    );
endinterface

// File: rtl/iic_gyro_seq.sv
// -----------------------------------------------------------------------------
// iic_gyro_seq
// Boots a gyro over an IIC byte driver (4-entry register init table), then
// periodically reads a 6-byte burst starting at RD_BASE and publishes it as
// three 16-bit big-endian axis values.
// Ports:
//   clk        : system clock
//   Rst        : asynchronous active-low reset
//   en         : enables periodic sampling
//   bus        : request/response bundle to the IIC driver (master side)
//   gyro_x/y/z : last complete sample
//   data_valid : one-cycle pulse when a new sample is published
//   init_done  : high once the init table has been written
//   err        : sticky timeout flag, cleared by the next publish
//   err_cnt    : saturating timeout count
// -----------------------------------------------------------------------------
module iic_gyro_seq #(
    parameter logic [7:0]  DEV_ADDR    = 8'hD0,
    parameter int unsigned BOOT_CYC    = 2000000,
    parameter int unsigned SAMPLE_DIV  = 100000,
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter logic [7:0]  RD_BASE     = 8'h43
) (
    input  logic                  clk,
    input  logic                  Rst,
    input  logic                  en,
    iic_gyro_seq_if.master        bus,
    output logic [15:0]           gyro_x,
    output logic [15:0]           gyro_y,
    output logic [15:0]           gyro_z,
    output logic                  data_valid,
    output logic                  init_done,
    output logic                  err,
    output logic [7:0]            err_cnt
);

    localparam logic [31:0] BOOT_LAST = 32'(BOOT_CYC - 32'd1);
    localparam logic [31:0] SDIV_LAST = 32'(SAMPLE_DIV - 32'd1);
    localparam logic [31:0] TO_LIMIT  = 32'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        BOOT      = 3'd0,
        INIT_REQ  = 3'd1,
        INIT_WAIT = 3'd2,
        IDLE      = 3'd3,
        RD_REQ    = 3'd4,
        RD_WAIT   = 3'd5,
        PUBLISH   = 3'd6,
        ERR       = 3'd7
    } state_t;

    // Init table: register address per entry
    function automatic logic [7:0] init_reg(input logic [2:0] idx);
        logic [7:0] v;
        case (idx)
            3'd0:    v = 8'h6B;
            3'd1:    v = 8'h19;
            3'd2:    v = 8'h1A;
            3'd3:    v = 8'h1B;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Init table: data byte per entry
    function automatic logic [7:0] init_data(input logic [2:0] idx);
        logic [7:0] v;
        case (idx)
            3'd0:    v = 8'h00;
            3'd1:    v = 8'h07;
            3'd2:    v = 8'h06;
            3'd3:    v = 8'h18;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_wait_cnt;
    logic [31:0] r_timer;
    logic [31:0] r_to_cnt;
    logic [2:0]  r_idx;
    logic        r_busy_q;
    logic [7:0]  r_buf [0:5];
    logic        r_write;
    logic        r_read;
    logic [7:0]  r_reg_addr;
    logic [7:0]  r_data;
    logic [15:0] r_gyro_x;
    logic [15:0] r_gyro_y;
    logic [15:0] r_gyro_z;
    logic        r_valid;
    logic        r_init_done;
    logic        r_err;
    logic [7:0]  r_err_cnt;

    logic        w_busy_fall;
    logic        w_timeout;
    logic        w_enter_req;
    logic        w_enter_err;
    logic        w_in_txn;

    assign w_busy_fall = r_busy_q & ~bus.IIC_Busy;
    assign w_timeout   = (r_to_cnt >= TO_LIMIT);
    assign w_in_txn    = (r_state == INIT_REQ) || (r_state == INIT_WAIT) ||
                         (r_state == RD_REQ)   || (r_state == RD_WAIT);
    assign w_enter_req = ((w_next_state == INIT_REQ) || (w_next_state == RD_REQ)) &&
                         (w_next_state != r_state);
    assign w_enter_err = (w_next_state == ERR) && (r_state != ERR);

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT: begin
                if (r_wait_cnt >= BOOT_LAST) w_next_state = INIT_REQ;
                else                         w_next_state = BOOT;
            end
            INIT_REQ: begin
                // Leave only once the driver has acknowledged an asserted strobe
                if (w_timeout)                     w_next_state = ERR;
                else if (r_write && bus.IIC_Busy)  w_next_state = INIT_WAIT;
                else                               w_next_state = INIT_REQ;
            end
            INIT_WAIT: begin
                if (w_timeout)                     w_next_state = ERR;
                else if (w_busy_fall) begin
                    if (r_idx == 3'd3)             w_next_state = IDLE;
                    else                           w_next_state = INIT_REQ;
                end else                           w_next_state = INIT_WAIT;
            end
            IDLE: begin
                if ((r_timer == 32'd0) && en)      w_next_state = RD_REQ;
                else                               w_next_state = IDLE;
            end
            RD_REQ: begin
                if (w_timeout)                     w_next_state = ERR;
                else if (r_read && bus.IIC_Busy)   w_next_state = RD_WAIT;
                else                               w_next_state = RD_REQ;
            end
            RD_WAIT: begin
                if (w_timeout)                     w_next_state = ERR;
                else if (w_busy_fall) begin
                    if (r_idx == 3'd5)             w_next_state = PUBLISH;
                    else                           w_next_state = RD_REQ;
                end else                           w_next_state = RD_WAIT;
            end
            PUBLISH: begin
                w_next_state = IDLE;
            end
            ERR: begin
                if (r_wait_cnt >= SDIV_LAST) begin
                    if (r_init_done)               w_next_state = IDLE;
                    else                           w_next_state = INIT_REQ;
                end else                           w_next_state = ERR;
            end
            default: begin
                w_next_state = BOOT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) r_state <= BOOT;
        else      r_state <= w_next_state;
    end

    // Shared wait counter for the boot delay and the error back-off
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst)                                       r_wait_cnt <= 32'd0;
        else if (w_enter_err)                           r_wait_cnt <= 32'd0;
        else if ((r_state == BOOT) || (r_state == ERR)) r_wait_cnt <= r_wait_cnt + 32'd1;
        else                                            r_wait_cnt <= 32'd0;
    end

    // Free-running sample timer, only counting once init has finished
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst)                     r_timer <= 32'd0;
        else if (!r_init_done)        r_timer <= 32'd0;
        else if (r_timer >= SDIV_LAST) r_timer <= 32'd0;
        else                          r_timer <= r_timer + 32'd1;
    end

    // Transaction timeout counter, restarted on every request
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst)             r_to_cnt <= 32'd0;
        else if (w_enter_req) r_to_cnt <= 32'd0;
        else if (w_in_txn)    r_to_cnt <= r_to_cnt + 32'd1;
        else                  r_to_cnt <= 32'd0;
    end

    // Table / byte index
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_idx <= 3'd0;
        end else if ((r_state == BOOT) || (r_state == IDLE) ||
                     (r_state == ERR)  || (r_state == PUBLISH)) begin
            r_idx <= 3'd0;
        end else if (((r_state == INIT_WAIT) && (w_next_state == INIT_REQ)) ||
                     ((r_state == RD_WAIT)   && (w_next_state == RD_REQ))) begin
            r_idx <= r_idx + 3'd1;
        end else begin
            r_idx <= r_idx;
        end
    end

    // Previous busy sample for falling-edge completion detection
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) r_busy_q <= 1'b0;
        else      r_busy_q <= bus.IIC_Busy;
    end

    // Burst byte buffer, captured on each read completion
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < 6; i++) r_buf[i] <= 8'h00;
        end else if ((r_state == RD_WAIT) &&
                     ((w_next_state == RD_REQ) || (w_next_state == PUBLISH))) begin
            r_buf[r_idx] <= bus.IIC_Read_Data;
        end else begin
            for (int i = 0; i < 6; i++) r_buf[i] <= r_buf[i];
        end
    end

    // Request fields, refreshed while a request state is active
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_reg_addr <= 8'h00;
            r_data     <= 8'h00;
        end else if (r_state == INIT_REQ) begin
            r_reg_addr <= init_reg(r_idx);
            r_data     <= init_data(r_idx);
        end else if (r_state == RD_REQ) begin
            r_reg_addr <= RD_BASE + {5'd0, r_idx};
            r_data     <= r_data;
        end else begin
            r_reg_addr <= r_reg_addr;
            r_data     <= r_data;
        end
    end

    // Request strobes: raised only on the second cycle of a request state, so
    // each strobe stays low for at least two cycles between requests
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_write <= 1'b0;
            r_read  <= 1'b0;
        end else begin
            r_write <= (r_state == INIT_REQ) && (w_next_state == INIT_REQ);
            r_read  <= (r_state == RD_REQ)   && (w_next_state == RD_REQ);
        end
    end

    // Published sample and valid pulse
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_gyro_x <= 16'h0000;
            r_gyro_y <= 16'h0000;
            r_gyro_z <= 16'h0000;
            r_valid  <= 1'b0;
        end else if (r_state == PUBLISH) begin
            r_gyro_x <= {r_buf[0], r_buf[1]};
            r_gyro_y <= {r_buf[2], r_buf[3]};
            r_gyro_z <= {r_buf[4], r_buf[5]};
            r_valid  <= 1'b1;
        end else begin
            r_valid  <= 1'b0;
        end
    end

    // Init completion flag
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst)                                                   r_init_done <= 1'b0;
        else if ((r_state == INIT_WAIT) && (w_next_state == IDLE))  r_init_done <= 1'b1;
        else                                                        r_init_done <= r_init_done;
    end

    // Error flag and saturating timeout count
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'h00;
        end else if (w_enter_err) begin
            r_err     <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'h01;
            else                    r_err_cnt <= r_err_cnt;
        end else if (r_state == PUBLISH) begin
            r_err     <= 1'b0;
        end else begin
            r_err     <= r_err;
        end
    end

    assign bus.Addr      = DEV_ADDR;
    assign bus.Reg_Addr  = {8'h00, r_reg_addr};
    assign bus.Data      = r_data;
    assign bus.Reg_2Addr = 1'b0;
    assign bus.IIC_Write = r_write;
    assign bus.IIC_Read  = r_read;

    assign gyro_x     = r_gyro_x;
    assign gyro_y     = r_gyro_y;
    assign gyro_z     = r_gyro_z;
    assign data_valid = r_valid;
    assign init_done  = r_init_done;
    assign err        = r_err;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_iic_gyro_seq.sv
// -----------------------------------------------------------------------------
// tb_iic_gyro_seq
// Bench for iic_gyro_seq with a behavioural IIC driver model (random latency,
// random busy length, register-file read data) and a transaction-level
// reference: expected init writes, expected read addresses and expected
// published words derived from the model's register contents.
// -----------------------------------------------------------------------------
module tb_iic_gyro_seq;

    localparam int        SAMPLE_DIV  = 5000;
    localparam int        TIMEOUT_CYC = 3000;
    localparam logic [7:0] RB         = 8'h43;

    logic        clk = 1'b0;
    logic        Rst;
    logic        en;
    logic [15:0] gyro_x, gyro_y, gyro_z;
    logic        data_valid, init_done, err;
    logic [7:0]  err_cnt;

    iic_gyro_seq_if bus ();

    iic_gyro_seq #(
        .DEV_ADDR    (8'hD0),
        .BOOT_CYC    (10),
        .SAMPLE_DIV  (SAMPLE_DIV),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .RD_BASE     (RB)
    ) dut (
        .clk        (clk),
        .Rst        (Rst),
        .en         (en),
        .bus        (bus),
        .gyro_x     (gyro_x),
        .gyro_y     (gyro_y),
        .gyro_z     (gyro_z),
        .data_valid (data_valid),
        .init_done  (init_done),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          is_read;
        logic [7:0]  dev;
        logic [15:0] reg_a;
        logic [7:0]  dat;
        int          rd_seq;
    } req_t;

    req_t        req_q[$];
    req_t        wr_log[$];
    logic [7:0]  rd_log[$];
    logic [15:0] vx[$], vy[$], vz[$];
    logic [7:0]  mem [0:255];
    int          drop_rd = -1;

    // Monitor state (written only by the monitor process)
    int   cyc = 0;
    int   rd_seq = 0;
    int   drop_rise_cyc = -1;
    int   err_rise_cyc = -1;
    int   fall_cnt = 0;
    int   init_rise_falls = -1;
    int   overlap_viol = 0;
    int   gap_viol = 0;
    int   w_low = 100, r_low = 100;
    logic prev_w = 1'b0, prev_r = 1'b0, prev_busy = 1'b0, prev_init = 1'b0, prev_err = 1'b0;

    // Monitor: protocol checks, request capture, published-sample capture
    always begin
        req_t m;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.IIC_Write && bus.IIC_Read) overlap_viol++;
        if (bus.IIC_Write) begin
            if (!prev_w) begin
                if (w_low < 2) gap_viol++;
                m.is_read = 1'b0; m.dev = bus.Addr; m.reg_a = bus.Reg_Addr;
                m.dat = bus.Data; m.rd_seq = -1;
                req_q.push_back(m);
                wr_log.push_back(m);
            end
            w_low = 0;
        end else begin
            w_low++;
        end
        if (bus.IIC_Read) begin
            if (!prev_r) begin
                if (r_low < 2) gap_viol++;
                m.is_read = 1'b1; m.dev = bus.Addr; m.reg_a = bus.Reg_Addr;
                m.dat = bus.Data; m.rd_seq = rd_seq;
                if (rd_seq == drop_rd) drop_rise_cyc = cyc;
                rd_seq++;
                req_q.push_back(m);
                rd_log.push_back(bus.Reg_Addr[7:0]);
            end
            r_low = 0;
        end else begin
            r_low++;
        end
        prev_w = bus.IIC_Write;
        prev_r = bus.IIC_Read;
        if (prev_busy && !bus.IIC_Busy) fall_cnt++;
        prev_busy = bus.IIC_Busy;
        if (init_done && !prev_init) init_rise_falls = fall_cnt;
        prev_init = init_done;
        if (err && !prev_err) err_rise_cyc = cyc;
        prev_err = err;
        if (data_valid) begin
            vx.push_back(gyro_x); vy.push_back(gyro_y); vz.push_back(gyro_z);
        end
    end

    // Behavioural IIC driver: random latency, busy only in "STOP", read data from mem
    initial begin
        req_t r;
        int   dly;
        bus.IIC_Busy      = 1'b0;
        bus.IIC_Read_Data = 8'h00;
        forever begin
            @(negedge clk);
            if (!Rst) begin
                req_q.delete();
                bus.IIC_Busy = 1'b0;
            end else if (req_q.size() > 0) begin
                r = req_q.pop_front();
                if (!(r.is_read && (r.rd_seq == drop_rd))) begin
                    dly = $urandom_range(2, 6);
                    for (int k = 0; k < dly && Rst; k++) @(negedge clk);
                    if (Rst) begin
                        if (r.is_read) bus.IIC_Read_Data = mem[r.reg_a[7:0]];
                        bus.IIC_Busy = 1'b1;
                        dly = $urandom_range(1, 3);
                        for (int k = 0; k < dly && Rst; k++) @(negedge clk);
                        bus.IIC_Busy = 1'b0;
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic rst_checks(input string tag);
        check({tag, "_write"},  {31'd0, bus.IIC_Write}, 32'd0);
        check({tag, "_read"},   {31'd0, bus.IIC_Read},  32'd0);
        check({tag, "_regaddr"}, {16'd0, bus.Reg_Addr}, 32'd0);
        check({tag, "_data"},   {24'd0, bus.Data},      32'd0);
        check({tag, "_gx"},     {16'd0, gyro_x},        32'd0);
        check({tag, "_gy"},     {16'd0, gyro_y},        32'd0);
        check({tag, "_gz"},     {16'd0, gyro_z},        32'd0);
        check({tag, "_valid"},  {31'd0, data_valid},    32'd0);
        check({tag, "_init"},   {31'd0, init_done},     32'd0);
        check({tag, "_err"},    {31'd0, err},           32'd0);
        check({tag, "_errcnt"}, {24'd0, err_cnt},       32'd0);
    endtask

    task automatic wait_init_and_check(input string tag, input int wr_mark, input int fall_mark);
        logic [7:0] exp_reg [4];
        logic [7:0] exp_dat [4];
        bit ok;
        exp_reg = '{8'h6B, 8'h19, 8'h1A, 8'h1B};
        exp_dat = '{8'h00, 8'h07, 8'h06, 8'h18};
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (init_done) ok = 1'b1;
        end
        check({tag, "_init_seen"}, {31'd0, ok}, 32'd1);
        check({tag, "_wr_count"}, 32'(wr_log.size() - wr_mark), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (wr_mark + i < wr_log.size()) begin
                check({tag, "_wr_dev"}, {24'd0, wr_log[wr_mark + i].dev}, 32'h0000_00D0);
                check({tag, "_wr_reg"}, {16'd0, wr_log[wr_mark + i].reg_a}, {24'd0, exp_reg[i]});
                check({tag, "_wr_dat"}, {24'd0, wr_log[wr_mark + i].dat}, {24'd0, exp_dat[i]});
            end
        end
        check({tag, "_falls_at_init"}, 32'(init_rise_falls - fall_mark), 32'd4);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 6; i++) mem[RB + 8'(i)] = 8'($urandom);
    endtask

    task automatic burst_check(input string tag, input int rd_mark, input int v_mark, input int bound);
        bit          ok;
        logic [15:0] ex, ey, ez;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (vx.size() > v_mark) ok = 1'b1;
        end
        check({tag, "_valid_seen"}, {31'd0, ok}, 32'd1);
        if (ok) begin
            ex = {mem[RB], mem[RB + 8'd1]};
            ey = {mem[RB + 8'd2], mem[RB + 8'd3]};
            ez = {mem[RB + 8'd4], mem[RB + 8'd5]};
            check({tag, "_gx"}, {16'd0, vx[v_mark]}, {16'd0, ex});
            check({tag, "_gy"}, {16'd0, vy[v_mark]}, {16'd0, ey});
            check({tag, "_gz"}, {16'd0, vz[v_mark]}, {16'd0, ez});
            check({tag, "_err_clr"}, {31'd0, err}, 32'd0);
            check({tag, "_rd_count"}, 32'(rd_log.size() - rd_mark), 32'd6);
            for (int i = 0; i < 6; i++) begin
                if (rd_mark + i < rd_log.size())
                    check({tag, "_rd_reg"}, {24'd0, rd_log[rd_mark + i]}, {24'd0, RB + 8'(i)});
            end
            repeat (20) @(negedge clk);
            check({tag, "_one_pulse"}, 32'(vx.size() - v_mark), 32'd1);
        end
    endtask

    initial begin
        int  rd_mark, v_mark, wr_mark, fall_mark, d;
        bit  ok;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        Rst = 1'b0;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        rst_checks("reset");

        // Init sequence
        Rst = 1'b1;
        wait_init_and_check("init", 0, 0);
        check("init_no_reads", 32'(rd_log.size()), 32'd0);

        // Fixed-pattern burst
        mem[RB]        = 8'h12; mem[RB + 8'd1] = 8'h34; mem[RB + 8'd2] = 8'h56;
        mem[RB + 8'd3] = 8'h78; mem[RB + 8'd4] = 8'h9A; mem[RB + 8'd5] = 8'hBC;
        rd_mark = rd_log.size(); v_mark = vx.size();
        en = 1'b1;
        burst_check("fixed", rd_mark, v_mark, SAMPLE_DIV + 2000);
        check("fixed_gx_lit", {16'd0, gyro_x}, 32'h0000_1234);
        check("fixed_gz_lit", {16'd0, gyro_z}, 32'h0000_9ABC);

        // Random bursts
        for (int n = 0; n < 2; n++) begin
            randomize_mem();
            rd_mark = rd_log.size(); v_mark = vx.size();
            burst_check("rand", rd_mark, v_mark, SAMPLE_DIV + 2000);
        end

        // Timeout on the 3rd read of the next burst
        randomize_mem();
        v_mark = vx.size();
        drop_rd = rd_seq + 2;
        ok = 1'b0;
        for (int i = 0; i < 10000 && !ok; i++) begin
            @(negedge clk);
            if (err) ok = 1'b1;
        end
        check("to_err_seen", {31'd0, ok}, 32'd1);
        check("to_err_cnt", {24'd0, err_cnt}, 32'd1);
        check("to_no_publish", 32'(vx.size() - v_mark), 32'd0);
        d = err_rise_cyc - drop_rise_cyc;
        check("to_delay_window", {31'd0, (d >= TIMEOUT_CYC - 5) && (d <= TIMEOUT_CYC + 5)}, 32'd1);
        rd_mark = rd_log.size(); v_mark = vx.size();
        burst_check("after_to", rd_mark, v_mark, 2 * SAMPLE_DIV + 2000);
        check("after_to_errcnt", {24'd0, err_cnt}, 32'd1);

        // en dropped during byte 2: burst completes, then no reads
        randomize_mem();
        rd_mark = rd_log.size(); v_mark = vx.size();
        ok = 1'b0;
        for (int i = 0; i < SAMPLE_DIV + 2000 && !ok; i++) begin
            @(negedge clk);
            if (rd_log.size() >= rd_mark + 3) ok = 1'b1;
        end
        check("enlow_byte2_seen", {31'd0, ok}, 32'd1);
        en = 1'b0;
        burst_check("enlow", rd_mark, v_mark, 2000);
        rd_mark = rd_log.size();
        repeat (3 * SAMPLE_DIV) @(negedge clk);
        check("enlow_no_reads", 32'(rd_log.size() - rd_mark), 32'd0);
        randomize_mem();
        v_mark = vx.size();
        en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < SAMPLE_DIV + 5 && !ok; i++) begin
            @(negedge clk);
            if (rd_log.size() > rd_mark) ok = 1'b1;
        end
        check("enhigh_restart", {31'd0, ok}, 32'd1);
        burst_check("enhigh", rd_mark, v_mark, 2000);

        // Reset in the middle of a read
        ok = 1'b0;
        for (int i = 0; i < SAMPLE_DIV + 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.IIC_Busy && (rd_log.size() > rd_mark + 6)) ok = 1'b1;
        end
        check("midrd_busy_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        Rst = 1'b0;
        repeat (2) @(negedge clk);
        rst_checks("midrd");
        fall_mark = fall_cnt;
        wr_mark   = wr_log.size();
        Rst = 1'b1;
        wait_init_and_check("reinit", wr_mark, fall_mark);

        // Protocol summary
        check("proto_overlap", 32'(overlap_viol), 32'd0);
        check("proto_gap", 32'(gap_viol), 32'd0);
        check("reg2addr", {31'd0, bus.Reg_2Addr}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
